// File: rtl/dmem_mmio_if.sv
// Core data-port bus into the data memory subsystem; read data is combinational
// in the same cycle the address and enables are presented.
interface dmem_mmio_if;
  logic [3:0]  ce_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] data_o;

  modport master (output ce_i, addr_i, data_i, we_i, sel_i, input data_o);
  modport slave  (input ce_i, addr_i, data_i, we_i, sel_i, output data_o);
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: byte-lane data RAM, GPIO register, cycle counter and a
// FIFO-fed 8N1 UART transmitter. Reads are combinational; all state updates on the rising edge.
module dmem_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int UART_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  dmem_mmio_if.slave  bus,
  output logic [31:0] gpio_o,
  output logic        uart_tx_o
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(UART_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(UART_DIV - 1);
  localparam logic [FW:0]   CNT_FULL  = (FW+1)'(FIFO_DEPTH);

  // Word addresses (byte address >> 2) of the MMIO registers at 0x1000_0000.
  localparam logic [29:0] WA_GPIO  = 30'h0400_0000;
  localparam logic [29:0] WA_CYCLE = 30'h0400_0001;
  localparam logic [29:0] WA_UTX   = 30'h0400_0002;
  localparam logic [29:0] WA_USTAT = 30'h0400_0003;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic          acc;
  logic          wr;
  logic          ram_hit;
  logic          gpio_hit;
  logic          cyc_hit;
  logic          utx_hit;
  logic          ustat_hit;
  logic [AW-1:0] ram_idx;
  logic [31:0]   lane_mask;
  logic          unused_addr_lsbs;

  assign acc              = |bus.ce_i;
  assign wr               = acc & bus.we_i & rst;
  assign ram_hit          = (bus.addr_i[31:AW+2] == '0);
  assign gpio_hit         = (bus.addr_i[31:2] == WA_GPIO);
  assign cyc_hit          = (bus.addr_i[31:2] == WA_CYCLE);
  assign utx_hit          = (bus.addr_i[31:2] == WA_UTX);
  assign ustat_hit        = (bus.addr_i[31:2] == WA_USTAT);
  assign ram_idx          = bus.addr_i[AW+1:2];
  assign unused_addr_lsbs = ^bus.addr_i[1:0];
  assign lane_mask        = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}},
                             {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};

  // Data RAM: contents are deliberately not reset.
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr && ram_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.sel_i[k]) mem_q[ram_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
      end
    end
  end

  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    gpio_d = gpio_q;
    if (wr && gpio_hit) gpio_d = (gpio_q & ~lane_mask) | (bus.data_i & lane_mask);
    cycle_d = (wr && cyc_hit) ? 32'd0 : cycle_q + 32'd1;
  end

  // UART TX FIFO
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [FW-1:0] wptr_q, wptr_d;
  logic [FW-1:0] rptr_q, rptr_d;
  logic [FW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push;
  logic          pop;

  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_empty = (cnt_q == '0);
  assign push_req   = wr & utx_hit & bus.sel_i[0];
  assign push       = push_req & ~fifo_full;

  always_comb begin
    wptr_d = wptr_q + FW'(push);
    rptr_d = rptr_q + FW'(pop);
    cnt_d  = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
    ovf_d  = ovf_q;
    if (wr && ustat_hit && bus.sel_i[0] && bus.data_i[3]) ovf_d = 1'b0;
    // A dropped push in the same cycle as a clear leaves the flag set.
    if (push_req && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= bus.data_i[7:0];
  end

  // UART transmitter
  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          baud_done;
  logic          tx_busy;

  assign baud_done = (baud_q == BAUD_LAST);
  assign tx_busy   = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (baud_done) state_d = S_DATA;
      S_DATA:  if (baud_done && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_done) state_d = fifo_empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    uart_tx_o = 1'b1;
    case (state_q)
      S_IDLE:  pop = !fifo_empty;
      S_START: uart_tx_o = 1'b0;
      S_DATA:  uart_tx_o = shreg_q[0];
      S_STOP:  pop = baud_done && !fifo_empty;
      default: ;
    endcase
  end

  // The STOP->START reload reuses the baud wrap, so consecutive frames have no gap.
  always_comb begin
    baud_d  = baud_done ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q == S_IDLE) baud_d = '0;
    if (pop) shreg_d = fifo_q[rptr_q];
    if (state_q == S_DATA && baud_done) begin
      bit_d   = bit_q + 3'd1;
      shreg_d = shreg_q >> 1;
    end
    if (state_q != S_DATA) bit_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  assign gpio_o = gpio_q;

  logic [31:0] cnt_wide;
  logic [3:0]  cnt_disp;
  logic [31:0] rdata;

  assign cnt_wide = 32'(cnt_q);
  assign cnt_disp = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];

  always_comb begin
    rdata = '0;
    if (ram_hit)        rdata = mem_q[ram_idx];
    else if (gpio_hit)  rdata = gpio_q;
    else if (cyc_hit)   rdata = cycle_q;
    else if (ustat_hit) rdata = {24'h0, cnt_disp, ovf_q, tx_busy, fifo_empty, fifo_full};
    bus.data_o = (rst && acc && !bus.we_i) ? rdata : '0;
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: bus reads and UART bytes are queued as expected
// values when driven and checked when the DUT produces them.
module tb_dmem_mmio;
  localparam int DIV = 4;
  localparam logic [31:0] A_GPIO = 32'h1000_0000;
  localparam logic [31:0] A_CYC  = 32'h1000_0004;
  localparam logic [31:0] A_UTX  = 32'h1000_0008;
  localparam logic [31:0] A_STAT = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] gpio;
  logic        uart_tx;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  sb_q [$];
  bit          mon_en   = 1'b1;
  bit          mon_busy = 1'b0;

  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_WORDS(256), .UART_DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gpio_o    (gpio),
    .uart_tx_o (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.ce_i   = '0;
    bus.we_i   = 1'b0;
    bus.sel_i  = '0;
    bus.addr_i = '0;
    bus.data_i = '0;
  endtask

  task automatic rd_now(input string tag, input logic [3:0] ce, input logic [31:0] addr,
                        input logic [31:0] exp);
    bus.ce_i   = ce;
    bus.we_i   = 1'b0;
    bus.sel_i  = 4'h0;
    bus.addr_i = addr;
    rd_q.push_back(exp);
    #2;
    chk(tag, bus.data_o, rd_q.pop_front());
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                        input logic [3:0] ce = 4'hF);
    @(negedge clk);
    rd_now(tag, ce, addr, exp);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    @(negedge clk);
    bus.ce_i   = 4'b1000;
    bus.we_i   = 1'b1;
    bus.sel_i  = sel;
    bus.addr_i = addr;
    bus.data_i = data;
    #2;
    chk("wr_dout_zero", bus.data_o, 32'h0);
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic push(input logic [7:0] b, input bit sent);
    if (sent) sb_q.push_back(b);
    bus_wr(A_UTX, {24'hABCDEF, b}, 4'b0001);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sb_q.size()) + 32'(mon_busy), 32'h0);
  endtask

  // Serial monitor: finds a start bit at a falling edge and samples mid-bit.
  initial begin : uart_mon
    bit         pending = 1'b0;
    logic [7:0] b;
    logic [31:0] exp_b;
    forever begin
      if (!pending) @(negedge clk);
      pending = 1'b0;
      if (mon_en && rst && uart_tx == 1'b0) begin
        mon_busy = 1'b1;
        repeat (DIV/2) @(negedge clk);
        chk("uart_start", 32'(uart_tx), 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        chk("uart_stop", 32'(uart_tx), 32'h1);
        if (sb_q.size() != 0) exp_b = {24'h0, sb_q.pop_front()};
        else                  exp_b = 32'hFFFF_FFFF;
        chk("uart_byte", {24'h0, b}, exp_b);
        repeat (DIV/2) @(negedge clk);
        chk("uart_gap", 32'(uart_tx), (sb_q.size() != 0) ? 32'h0 : 32'h1);
        pending  = (uart_tx == 1'b0) && (sb_q.size() != 0);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus_idle();
    repeat (3) @(negedge clk);
    rd_now("rd_in_reset", 4'hF, A_STAT, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_gpio", gpio, 32'h0);
    chk("rst_tx", 32'(uart_tx), 32'h1);
    rd_now("cyc_0", 4'hF, A_CYC, 32'd0);
    repeat (4) @(negedge clk);
    bus_rd("cyc_5", A_CYC, 32'd5);
    bus_rd("rst_stat", A_STAT, 32'h2);

    bus_wr(32'h10, 32'h1122_3344, 4'hF);
    bus_wr(32'h10, 32'hAABB_CCDD, 4'b0101);
    bus_rd("ram_lanes", 32'h10, 32'h11BB_33DD);
    bus_rd("ram_ce0", 32'h14, 32'h0, 4'h0);
    bus_wr(32'h0, 32'h0000_0055, 4'hF);
    bus_wr(32'h3FC, 32'h0BAD_F00D, 4'hF);
    bus_wr(32'h400, 32'hFFFF_FFFF, 4'hF);
    bus_rd("ram_top", 32'h3FF, 32'h0BAD_F00D, 4'b0100);
    bus_rd("ram_oob", 32'h400, 32'h0);
    bus_rd("ram_w0", 32'h0, 32'h0000_0055);

    bus_wr(A_GPIO, 32'hDEAD_BEEF, 4'b0011);
    chk("gpio_lanes", gpio, 32'h0000_BEEF);
    bus_rd("gpio_rd", A_GPIO, 32'h0000_BEEF);
    bus_wr(A_GPIO, 32'h1234_5678, 4'b1000);
    chk("gpio_hi", gpio, 32'h1200_BEEF);
    bus_wr(32'h2000_0000, 32'hCAFE_F00D, 4'hF);
    bus_rd("unmapped", 32'h2000_0000, 32'h0);
    chk("gpio_keep", gpio, 32'h1200_BEEF);
    bus_rd("utx_rd", A_UTX, 32'h0);

    bus_wr(A_CYC, 32'h1234_5678, 4'h0);
    bus_rd("cyc_clr", A_CYC, 32'd0);
    bus_rd("cyc_clr_next", A_CYC, 32'd1);
    @(negedge clk);
    dut.cycle_q = 32'hFFFF_FFFF;
    rd_now("cyc_max", 4'hF, A_CYC, 32'hFFFF_FFFF);
    bus_rd("cyc_wrap", A_CYC, 32'd0);

    push(8'hA5, 1'b1);
    bus_rd("stat_pend", A_STAT, 32'h10);
    bus_rd("stat_busy", A_STAT, 32'h6);
    repeat (38) @(negedge clk);
    bus_rd("stat_stop_last", A_STAT, 32'h6);
    bus_rd("stat_done", A_STAT, 32'h2);
    drain("drain_a5", 200);

    for (int i = 1; i <= 10; i++) push(8'(i), i <= 9);
    bus_rd("stat_full", A_STAT, 32'h8D);
    bus_wr(A_STAT, 32'h0000_0008, 4'b0010);
    bus_rd("stat_ovf_keep", A_STAT, 32'h8D);
    bus_wr(A_STAT, 32'h0000_0008, 4'b0001);
    bus_rd("stat_ovf_clr", A_STAT, 32'h85);
    drain("drain_burst", 1000);
    bus_rd("stat_idle", A_STAT, 32'h2);

    mon_en = 1'b0;
    push(8'h3C, 1'b0);
    repeat (12) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_now("rd_in_reset2", 4'hF, A_GPIO, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_tx", 32'(uart_tx), 32'h1);
    chk("mid_rst_gpio", gpio, 32'h0);
    rd_now("mid_rst_stat", 4'hF, A_STAT, 32'h2);
    mon_en = 1'b1;
    push(8'h5A, 1'b1);
    drain("drain_5a", 200);
    bus_rd("stat_end", A_STAT, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory subsystem downstream of the `openmips` core's data port (`ram_*` signals). It decodes each access into one of three targets:
- a word-organised data RAM with byte-lane writes;
- a GPIO output register;
- a free-running cycle counter and an 8N1 UART transmitter fed by a small FIFO.

Reads are combinational because the core's MEM stage samples read data in the same cycle it presents the address. All writes and internal state update on the rising clock edge.

## Interface
Parameters:
- `RAM_WORDS`, 1024 — data RAM depth in 32-bit words; power of two.
- `UART_DIV`, 434 — clocks per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 8 — UART TX FIFO entries; power of two.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous and active-low.
- `ce_i`  in  4  — access enable; access is valid when any bit is 1.
- `addr_i`  in  32  — byte address.
- `data_i`  in  32  — write data.
- `we_i`  in  1  — 1 = write, 0 = read.
- `sel_i`  in  4  — byte-lane enable; `sel_i[k]` gates `data_i[8k+7:8k]`.
- `data_o`  out  32  — read data, combinational.
- `gpio_o`  out  32  — GPIO register.
- `uart_tx_o`  out  1  — UART serial output; idles high.

## Operation
Address map (`addr_i[1:0]` ignored; only full words are decoded):
- `0x0000_0000` to `RAM_WORDS*4-1`: RAM, word index `addr_i[log2(RAM_WORDS)+1:2]`.
- `0x1000_0000` GPIO: read/write; writes are byte-lane.
- `0x1000_0004` CYCLE:
  - read returns the counter;
  - any write clears it to 0, ignoring data and lanes.
- `0x1000_0008` UART_TX: a write with `sel_i[0]=1` pushes `data_i[7:0]`; reads return 0.
- `0x1000_000C` UART_STAT: read returns
  - bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow (sticky);
  - bits[7:4] fifo count, saturating display at 15;
  - other bits 0.
  
  Writing with `data_i[3]=1` and `sel_i[0]=1` clears overflow.
- Any other address: reads return 0; writes are ignored.

Access rules:
- Reads return the full word regardless of `sel_i`.
- `data_o` is 0 when no `ce_i` bit is set, when `we_i=1`, or when `rst=0`.

Cycle counter:
- Increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0.
- A clearing write takes priority over the increment: the value after that edge is 0.

UART FIFO:
- Push while full: the byte is dropped and overflow is set.
- Push and pop on the same edge: both take effect, and count is unchanged.

UART FSM (states IDLE, START, DATA, STOP):
- IDLE: if the FIFO is not empty, pop the byte into the shift register and go to START.
- START: `uart_tx_o=0` for `UART_DIV` cycles.
- DATA: 8 bits, LSB first, each held for `UART_DIV` cycles; a bit counter runs 0 to 7.
- STOP: `uart_tx_o=1` for `UART_DIV` cycles. At the end of STOP:
  - FIFO not empty → pop and go directly to START (no idle gap);
  - FIFO empty → go to IDLE.
- A baud counter runs 0 to `UART_DIV-1` and resets on each state or bit change.
- `tx_busy` = (state != IDLE).

RAM contents are not reset.

## Timing
- Reset, on the edge where `rst=0`:
  - `gpio_o=0`, `uart_tx_o=1`, counter 0;
  - FIFO empty, overflow 0, FSM IDLE, baud and bit counters 0.
- Reset during a frame aborts it immediately; the line returns high on the next cycle.
- Read latency is 0 cycles (combinational from `addr_i`/`ce_i`).
- Write latency: data commits at the edge; a read in the following cycle sees the new value.
- A same-cycle read is impossible (`we_i=1` zeroes `data_o`).
- CYCLE reads the pre-edge value. The first cycle after reset release reads 0, the next reads 1.
- UART sequence for a push committed at edge E into an empty FIFO with the FSM idle:
  - edge E+1: pop, enter START; `uart_tx_o` goes low after E+1;
  - total frame length is `10*UART_DIV` cycles;
  - `tx_busy` reads 1 from the cycle after E+1;
  - fifo_empty reads 1 from the cycle after E+1.
- Back-to-back frames: the next start bit begins on the cycle immediately after the previous stop bit's last cycle.

## Test plan
- **RAM byte lanes:**
  1. Write `0x1122_3344` to `0x10`, `sel=1111`.
  2. Write `0xAABB_CCDD` to `0x10`, `sel=0101`.
  3. Read `0x10` → `0x11BB_33DD`.
  4. Read `0x14` with `ce_i=0` → 0.
- **GPIO / unmapped:**
  1. Write `0xDEAD_BEEF` to `0x1000_0000`, `sel=0011`, from reset → `gpio_o=0x0000_BEEF`.
  2. Write to `0x2000_0000`, then read it → 0; `gpio_o` unchanged.
- **Counter:**
  1. Release reset, read CYCLE on cycles 0 and 5 → 0 and 5.
  2. Write CYCLE, read it the next cycle → 0.
  3. Force the counter to `0xFFFF_FFFF` via hierarchical deposit, then step → 0.
- **UART frame (`UART_DIV=4`):**
  1. Push `0xA5`.
  2. Sample `uart_tx_o` mid-bit → 0, 1,0,1,0,0,1,0,1, 1.
  3. Frame spans 40 cycles; `tx_busy` returns to 0 after it.
- **FIFO full/overflow (`FIFO_DEPTH=8`, `UART_DIV=4`):**
  1. Push 10 bytes on consecutive cycles → first byte popped immediately; 8 held, full=1; 10th dropped, overflow=1.
  2. Bytes transmitted back-to-back with no idle gap, in order 1 to 9.
  3. Write STAT with bit3 → overflow=0.
- **Reset mid-frame:** assert `rst=0` during DATA for 1 cycle → `uart_tx_o=1`, STAT reads `0x0000_0002`, `gpio_o=0`; a push then transmits a normal frame.
